// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the pipeline stages:
// opcodes, funct3 encodings, NOP bubble, mem-stage FSM state.
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPI    = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    S_IDLE,
    S_BUS
  } mem_state_t;

  function automatic logic f3_legal(
    input logic       store,
    input logic [2:0] f3
  );
    if (store)
      return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store sel/data, load extract/extend,
// misalignment. Ports: funct3, addr (low bits), st_data, ld_raw in;
// sel, st_wdata, ld_data, misaligned out.
module mem_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  sel,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] sh;
  logic        sx;

  assign sh = ld_raw >> {addr, 3'b000};
  // funct3[2] clear means signed load
  assign sx = ~funct3[2];

  always_comb begin
    sel        = 4'b0000;
    st_wdata   = st_data;
    ld_data    = 32'h0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        sel      = 4'b0001 << addr;
        st_wdata = {4{st_data[7:0]}};
        ld_data  = {{24{sx & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sel        = 4'b0011 << addr;
        st_wdata   = {2{st_data[15:0]}};
        ld_data    = {{16{sx & sh[15]}}, sh[15:0]};
        misaligned = addr[0];
      end
      2'b10: begin
        sel        = 4'b1111;
        st_wdata   = st_data;
        ld_data    = sh;
        misaligned = |addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// RV32I memory stage: Wishbone-style data access, load formatting,
// exception flags, registered bundle to write-back.
// Ports: clk_i/rst_i, execute-side inputs (valid_i, flush_i, pc_i,
// instruction_i, funct3_i, alu_d_i, rs2_d_i, e_*_i), stall_o,
// registered write-back outputs (*_o), dbus_* master interface.
// STAGE_MEM_ACCESS_FAULT_EN adds e_ld/st_access_fault_o raised on
// bus error or wait timeout; without it those return 0 silently.
module stage_mem
  import rv32_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] rs2_d_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  output logic        stall_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [2:0]  funct3_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
`ifdef STAGE_MEM_ACCESS_FAULT_EN
  output logic        e_ld_access_fault_o,
  output logic        e_st_access_fault_o,
`endif
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  output logic        dbus_stb_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  mem_state_t  state_q;
  logic [WW-1:0] wait_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        st_q;
  logic        flushed_q;

  logic        in_bus;
  logic        is_ld;
  logic        is_st;
  logic        mem_op;
  logic        f3_ok;
  logic        up_exc;
  logic        take;
  logic        go;
  logic        mis_ok;
  logic        tmo;
  logic        done;
  logic        fail;
  logic        kill;
  logic [2:0]  al_f3;
  logic [1:0]  al_a;
  logic [3:0]  al_sel;
  logic [31:0] al_wdat;
  logic [31:0] al_ldat;
  logic        al_mis;

  assign in_bus = (state_q == S_BUS);
  assign is_ld  = (instruction_i[6:0] == LOAD);
  assign is_st  = (instruction_i[6:0] == STORE);
  assign mem_op = is_ld | is_st;
  assign f3_ok  = f3_legal(is_st, funct3_i);
  assign up_exc = e_illegal_inst_i | e_inst_addr_mis_i;
  assign take   = valid_i & ~flush_i;
  assign go     = mem_op & f3_ok & ~al_mis & ~up_exc;
  assign mis_ok = f3_ok & al_mis & ~up_exc;

  // In BUS the aligner formats the returning word for the held access
  assign al_f3 = in_bus ? f3_q : funct3_i;
  assign al_a  = in_bus ? addr_q[1:0] : alu_d_i[1:0];

  mem_align u_align (
    .funct3     (al_f3),
    .addr       (al_a),
    .st_data    (rs2_d_i),
    .ld_raw     (dbus_dat_i),
    .sel        (al_sel),
    .st_wdata   (al_wdat),
    .ld_data    (al_ldat),
    .misaligned (al_mis)
  );

  assign tmo  = (wait_q == WW'(MAX_WAIT));
  assign done = in_bus & (dbus_ack_i | dbus_err_i | tmo);
  assign fail = dbus_err_i | (tmo & ~dbus_ack_i);
  assign kill = flushed_q | flush_i;

  assign stall_o = in_bus ? ~done : (take & go);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= S_IDLE;
      wait_q            <= '0;
      pc_q              <= '0;
      inst_q            <= '0;
      addr_q            <= '0;
      f3_q              <= '0;
      st_q              <= 1'b0;
      flushed_q         <= 1'b0;
      pc_o              <= '0;
      instruction_o     <= NOP_INST;
      funct3_o          <= '0;
      alu_d_o           <= '0;
      mem_d_o           <= '0;
      mem_addr_o        <= '0;
      e_illegal_inst_o  <= 1'b0;
      e_inst_addr_mis_o <= 1'b0;
      e_ld_addr_mis_o   <= 1'b0;
      e_st_addr_mis_o   <= 1'b0;
      dbus_addr_o       <= '0;
      dbus_dat_o        <= '0;
      dbus_sel_o        <= '0;
      dbus_we_o         <= 1'b0;
      dbus_cyc_o        <= 1'b0;
      dbus_stb_o        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take && go) begin
            state_q     <= S_BUS;
            wait_q      <= '0;
            flushed_q   <= 1'b0;
            pc_q        <= pc_i;
            inst_q      <= instruction_i;
            f3_q        <= funct3_i;
            addr_q      <= alu_d_i;
            st_q        <= is_st;
            dbus_addr_o <= {alu_d_i[31:2], 2'b00};
            dbus_dat_o  <= al_wdat;
            dbus_sel_o  <= al_sel;
            dbus_we_o   <= is_st;
            dbus_cyc_o  <= 1'b1;
            dbus_stb_o  <= 1'b1;
            // write-back sees a bubble while the access is in flight
            instruction_o     <= NOP_INST;
            e_illegal_inst_o  <= 1'b0;
            e_inst_addr_mis_o <= 1'b0;
            e_ld_addr_mis_o   <= 1'b0;
            e_st_addr_mis_o   <= 1'b0;
          end else if (take) begin
            pc_o              <= pc_i;
            instruction_o     <= instruction_i;
            funct3_o          <= funct3_i;
            alu_d_o           <= alu_d_i;
            mem_addr_o        <= alu_d_i;
            mem_d_o           <= '0;
            e_illegal_inst_o  <= e_illegal_inst_i | (mem_op & ~f3_ok);
            e_inst_addr_mis_o <= e_inst_addr_mis_i;
            e_ld_addr_mis_o   <= is_ld & mis_ok;
            e_st_addr_mis_o   <= is_st & mis_ok;
          end else begin
            instruction_o     <= NOP_INST;
            e_illegal_inst_o  <= 1'b0;
            e_inst_addr_mis_o <= 1'b0;
            e_ld_addr_mis_o   <= 1'b0;
            e_st_addr_mis_o   <= 1'b0;
          end
        end
        S_BUS: begin
          if (done) begin
            state_q    <= S_IDLE;
            dbus_cyc_o <= 1'b0;
            dbus_stb_o <= 1'b0;
            if (kill) begin
              instruction_o <= NOP_INST;
            end else begin
              pc_o          <= pc_q;
              instruction_o <= inst_q;
              funct3_o      <= f3_q;
              alu_d_o       <= addr_q;
              mem_addr_o    <= addr_q;
              mem_d_o       <= (fail | st_q) ? 32'h0 : al_ldat;
            end
            e_illegal_inst_o  <= 1'b0;
            e_inst_addr_mis_o <= 1'b0;
            e_ld_addr_mis_o   <= 1'b0;
            e_st_addr_mis_o   <= 1'b0;
          end else begin
            wait_q    <= wait_q + WW'(1);
            flushed_q <= flushed_q | flush_i;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef STAGE_MEM_ACCESS_FAULT_EN
  logic flt_wr;
  logic flt;

  // fault flags follow every write of the output register
  assign flt_wr = ~in_bus | done;
  assign flt    = in_bus & ~kill & fail;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_ld_access_fault_o <= 1'b0;
      e_st_access_fault_o <= 1'b0;
    end else if (flt_wr) begin
      e_ld_access_fault_o <= flt & ~st_q;
      e_st_access_fault_o <= flt & st_q;
    end
  end
`endif

endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: directed loads/stores, faults,
// flush, timeout and reset; a monitor checks each write-back result.
module tb_stage_mem;
  import rv32_pkg::*;

  localparam int MW = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i, flush_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, rs2_d_i;
  logic [2:0]  funct3_i;
  logic        e_illegal_inst_i, e_inst_addr_mis_i;
  logic        stall_o;
  logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
  logic [2:0]  funct3_o;
  logic        e_illegal_inst_o, e_inst_addr_mis_o;
  logic        e_ld_addr_mis_o, e_st_addr_mis_o;
  logic        ldf, stf;
  logic [31:0] dbus_addr_o, dbus_dat_o, dbus_dat_i;
  logic [3:0]  dbus_sel_o;
  logic        dbus_we_o, dbus_cyc_o, dbus_stb_o;
  logic        dbus_ack_i, dbus_err_i;

  always #5 clk_i = ~clk_i;

  stage_mem #(.MAX_WAIT(MW)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .valid_i           (valid_i),
    .flush_i           (flush_i),
    .pc_i              (pc_i),
    .instruction_i     (instruction_i),
    .funct3_i          (funct3_i),
    .alu_d_i           (alu_d_i),
    .rs2_d_i           (rs2_d_i),
    .e_illegal_inst_i  (e_illegal_inst_i),
    .e_inst_addr_mis_i (e_inst_addr_mis_i),
    .stall_o           (stall_o),
    .pc_o              (pc_o),
    .instruction_o     (instruction_o),
    .funct3_o          (funct3_o),
    .alu_d_o           (alu_d_o),
    .mem_d_o           (mem_d_o),
    .mem_addr_o        (mem_addr_o),
    .e_illegal_inst_o  (e_illegal_inst_o),
    .e_inst_addr_mis_o (e_inst_addr_mis_o),
    .e_ld_addr_mis_o   (e_ld_addr_mis_o),
    .e_st_addr_mis_o   (e_st_addr_mis_o),
`ifdef STAGE_MEM_ACCESS_FAULT_EN
    .e_ld_access_fault_o (ldf),
    .e_st_access_fault_o (stf),
`endif
    .dbus_addr_o       (dbus_addr_o),
    .dbus_dat_o        (dbus_dat_o),
    .dbus_sel_o        (dbus_sel_o),
    .dbus_we_o         (dbus_we_o),
    .dbus_cyc_o        (dbus_cyc_o),
    .dbus_stb_o        (dbus_stb_o),
    .dbus_dat_i        (dbus_dat_i),
    .dbus_ack_i        (dbus_ack_i),
    .dbus_err_i        (dbus_err_i)
  );

`ifndef STAGE_MEM_ACCESS_FAULT_EN
  assign ldf = 1'b0;
  assign stf = 1'b0;
  localparam logic [5:0] FLT_LD = 6'b000000;
`else
  localparam logic [5:0] FLT_LD = 6'b000010;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] md;
    logic [31:0] ma;
    logic [5:0]  fl;
  } rec_t;

  rec_t  exp_q[$];
  string nam_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  int    ack_at   = 0;
  bit    err_mode = 1'b0;
  int    flush_at = -1;
  int    bcnt     = 0;

  int          stalls, bcyc;
  logic [31:0] out_inst, b_addr, b_dat;
  logic [3:0]  b_sel;
  logic        b_we;

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [2:0] f3);
    return {17'h0, f3, 5'd1, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // slave model: ack (or err) on the ack_at-th cycle of cyc&stb
  always @(negedge clk_i) begin
    if (dbus_cyc_o && dbus_stb_o) begin
      bcnt       = bcnt + 1;
      dbus_ack_i = (ack_at != 0) && (bcnt == ack_at) && !err_mode;
      dbus_err_i = (ack_at != 0) && (bcnt == ack_at) && err_mode;
    end else begin
      bcnt       = 0;
      dbus_ack_i = 1'b0;
      dbus_err_i = 1'b0;
    end
  end

  // monitor: every non-bubble write-back result pops the scoreboard
  always @(posedge clk_i) begin
    rec_t  act, e;
    string nm;
    #2;
    if (!rst_i && instruction_o !== NOP_INST) begin
      act = '{pc_o, instruction_o, funct3_o, alu_d_o, mem_d_o,
              mem_addr_o, {e_illegal_inst_o, e_inst_addr_mis_o,
              e_ld_addr_mis_o, e_st_addr_mis_o, ldf, stf}};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h", act);
      end else begin
        e  = exp_q.pop_front();
        nm = nam_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  task automatic run(input string nm, input logic [6:0] op,
                     input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] addr, input logic [31:0] rs2,
                     input logic [1:0] up, input bit push,
                     input logic [31:0] emd, input logic [5:0] efl);
    int idx;
    bit s;
    valid_i           = 1'b1;
    pc_i              = pc;
    instruction_i     = mk(op, f3);
    funct3_i          = f3;
    alu_d_i           = addr;
    rs2_d_i           = rs2;
    e_illegal_inst_i  = up[1];
    e_inst_addr_mis_i = up[0];
    if (push) begin
      exp_q.push_back('{pc, mk(op, f3), f3, addr, emd, addr, efl});
      nam_q.push_back(nm);
    end
    stalls = 0;
    bcyc   = 0;
    idx    = 0;
    forever begin
      flush_i = (idx == flush_at);
      @(negedge clk_i);
      #2;
      if (dbus_cyc_o) begin
        bcyc++;
        b_addr = dbus_addr_o;
        b_dat  = dbus_dat_o;
        b_sel  = dbus_sel_o;
        b_we   = dbus_we_o;
      end
      s = stall_o;
      if (s) stalls++;
      @(posedge clk_i);
      #1;
      idx++;
      if (!s) break;
      if (idx > 4 * MW) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_stall_bound: stalled %0d cycles", nm, idx);
        break;
      end
    end
    out_inst          = instruction_o;
    valid_i           = 1'b0;
    flush_i           = 1'b0;
    e_illegal_inst_i  = 1'b0;
    e_inst_addr_mis_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    valid_i = 0; flush_i = 0; pc_i = 0; instruction_i = 0;
    funct3_i = 0; alu_d_i = 0; rs2_d_i = 0;
    e_illegal_inst_i = 0; e_inst_addr_mis_i = 0;
    dbus_dat_i = 0; dbus_ack_i = 0; dbus_err_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_inst", instruction_o, NOP_INST);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_memd", mem_d_o, 32'h0);
    chk("rst_cyc_stb", {30'h0, dbus_cyc_o, dbus_stb_o}, 32'h0);
    chk("rst_bus", dbus_addr_o | dbus_dat_o | {28'h0, dbus_sel_o},
        32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    ack_at = 2;
    dbus_dat_i = 32'hDEADBEEF;
    run("lw_100", LOAD, F3_W, 32'h1000, 32'h100, 0, 2'b00, 1,
        32'hDEADBEEF, 6'b0);
    chk("lw_stall_cycles", stalls, 2);
    chk("lw_bus_addr", b_addr, 32'h100);
    chk("lw_bus_sel_we", {27'h0, b_sel, b_we}, {27'h0, 4'b1111, 1'b0});

    dbus_dat_i = 32'h80FFFF7F;
    run("lb_103", LOAD, F3_B, 32'h1004, 32'h103, 0, 2'b00, 1,
        32'hFFFFFF80, 6'b0);
    chk("lb_bus_addr", b_addr, 32'h100);
    run("lbu_103", LOAD, F3_BU, 32'h1008, 32'h103, 0, 2'b00, 1,
        32'h00000080, 6'b0);
    run("lh_102", LOAD, F3_H, 32'h100C, 32'h102, 0, 2'b00, 1,
        32'hFFFF80FF, 6'b0);
    run("lhu_102", LOAD, F3_HU, 32'h1010, 32'h102, 0, 2'b00, 1,
        32'h000080FF, 6'b0);

    run("sh_202", STORE, F3_H, 32'h1014, 32'h202, 32'h1234ABCD,
        2'b00, 1, 32'h0, 6'b0);
    chk("sh_sel", {28'h0, b_sel}, 32'hC);
    chk("sh_dat", b_dat, 32'hABCDABCD);
    chk("sh_we", {31'h0, b_we}, 32'h1);
    chk("sh_addr", b_addr, 32'h200);
    run("sb_201", STORE, F3_B, 32'h1018, 32'h201, 32'h000000EF,
        2'b00, 1, 32'h0, 6'b0);
    chk("sb_sel", {28'h0, b_sel}, 32'h2);
    chk("sb_dat", b_dat, 32'hEFEFEFEF);
    run("sw_300", STORE, F3_W, 32'h101C, 32'h300, 32'hCAFEF00D,
        2'b00, 1, 32'h0, 6'b0);
    chk("sw_sel", {28'h0, b_sel}, 32'hF);
    chk("sw_dat", b_dat, 32'hCAFEF00D);

    run("lw_mis_102", LOAD, F3_W, 32'h1020, 32'h102, 0, 2'b00, 1,
        32'h0, 6'b001000);
    chk("lw_mis_no_cyc", bcyc, 0);
    run("sh_mis_201", STORE, F3_H, 32'h1024, 32'h201, 0, 2'b00, 1,
        32'h0, 6'b000100);
    chk("sh_mis_no_cyc", bcyc, 0);
    run("ld_f3_3", LOAD, 3'd3, 32'h1028, 32'h100, 0, 2'b00, 1,
        32'h0, 6'b100000);
    chk("ld_f3_3_no_cyc", bcyc, 0);
    run("st_f3_4", STORE, 3'd4, 32'h102C, 32'h100, 0, 2'b00, 1,
        32'h0, 6'b100000);
    run("lw_up_ill", LOAD, F3_W, 32'h1030, 32'h100, 0, 2'b10, 1,
        32'h0, 6'b100000);
    chk("lw_up_ill_no_cyc", bcyc, 0);
    run("sw_up_iam", STORE, F3_W, 32'h1034, 32'h104, 0, 2'b01, 1,
        32'h0, 6'b010000);
    run("addi", OPI, 3'd0, 32'h1038, 32'h5, 0, 2'b00, 1,
        32'h0, 6'b0);
    chk("addi_no_stall", stalls, 0);

    ack_at = 4;
    flush_at = 2;
    run("lw_flush", LOAD, F3_W, 32'h103C, 32'h100, 0, 2'b00, 0,
        32'h0, 6'b0);
    flush_at = -1;
    chk("flush_cyc_held", bcyc, 4);
    chk("flush_bubble", out_inst, NOP_INST);

    ack_at = 2;
    err_mode = 1'b1;
    run("lh_err", LOAD, F3_H, 32'h1040, 32'h104, 0, 2'b00, 1,
        32'h0, FLT_LD);
    err_mode = 1'b0;

    ack_at = 0;
    run("lw_timeout", LOAD, F3_W, 32'h1044, 32'h108, 0, 2'b00, 1,
        32'h0, FLT_LD);
    n_tests++;
    if (bcyc < MW || bcyc > MW + 1) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d cycles required %0d..%0d",
               bcyc, MW, MW + 1);
    end

    valid_i = 1'b1;
    pc_i = 32'h1048;
    instruction_i = mk(LOAD, F3_W);
    funct3_i = F3_W;
    alu_d_i = 32'h400;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    chk("midrst_cyc_before", {31'h0, dbus_cyc_o}, 32'h1);
    rst_i = 1'b1;
    valid_i = 1'b0;
    #1;
    chk("midrst_cyc_stb", {30'h0, dbus_cyc_o, dbus_stb_o}, 32'h0);
    chk("midrst_inst", instruction_o, NOP_INST);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    ack_at = 2;
    dbus_dat_i = 32'h0BADF00D;
    run("lw_after_rst", LOAD, F3_W, 32'h104C, 32'h10, 0, 2'b00, 1,
        32'h0BADF00D, 6'b0);
    repeat (3) @(posedge clk_i);
    #3;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
